// File: rtl/split_target_mem.sv
// Split-capable byte-memory target on the serial bus.
// Writes complete in place. Reads are answered with a split ack; after
// SPLIT_LATENCY cycles the block requests the bus back, hands the byte to
// the port on grant, and holds the bus while the port shifts it out.
module split_target_mem #(
  parameter int ADDR_WIDTH    = 12,
  parameter int SPLIT_LATENCY = 8,
  parameter int TX_CYCLES     = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] target_addr_in,
  input  logic        target_addr_in_valid,
  input  logic [7:0]  target_data_in,
  input  logic        target_data_in_valid,
  input  logic        split_grant,
  output logic [7:0]  target_data_out,
  output logic        target_data_out_valid,
  output logic        target_ready,
  output logic        target_ack,
  output logic        target_split_ack,
  output logic        split_req,
  output logic        txn_dropped
);

  typedef enum logic [1:0] {IDLE, SPLIT_WAIT, REQ, TX_HOLD} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] readAddr_q, readAddr_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  splitAck_q, splitAck_d;
  logic                  splitReq_q, splitReq_d;
  logic [7:0]            dataOut_q, dataOut_d;
  logic                  dataValid_q, dataValid_d;
  logic                  dropped_q, dropped_d;
  logic                  memWe;

  logic [7:0]            mem [2**ADDR_WIDTH];

  // The address decoder already selected us, so the upper bus bits carry no
  // information here; only the low bits index the array (aliasing is intended).
  logic [ADDR_WIDTH-1:0] strobeAddr;
  logic                  unusedAddrBits;
  assign strobeAddr     = target_addr_in[ADDR_WIDTH-1:0];
  assign unusedAddrBits = ^target_addr_in[15:ADDR_WIDTH];

  // Next-state and output decode; every pulse output defaults low each cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    readAddr_d  = readAddr_q;
    ack_d       = 1'b0;
    splitAck_d  = 1'b0;
    splitReq_d  = splitReq_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    dropped_d   = 1'b0;
    memWe       = 1'b0;

    case (state_q)
      IDLE: begin
        if (target_addr_in_valid && target_data_in_valid) begin
          memWe = 1'b1;
          ack_d = 1'b1;
        end else if (target_addr_in_valid) begin
          readAddr_d = strobeAddr;
          cnt_d      = 8'(SPLIT_LATENCY);
          splitAck_d = 1'b1;
          state_d    = SPLIT_WAIT;
        end
      end
      SPLIT_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          splitReq_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (split_grant) begin
          dataOut_d   = mem[readAddr_q];
          dataValid_d = 1'b1;
          cnt_d       = 8'(TX_CYCLES);
          state_d     = TX_HOLD;
        end
      end
      TX_HOLD: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          splitReq_d = 1'b0;
          ack_d      = 1'b1;
          dataOut_d  = 8'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (target_addr_in_valid || target_data_in_valid)) begin
      dropped_d = 1'b1;
    end

    ready_d = (state_d == IDLE);
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      readAddr_q  <= '0;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      splitAck_q  <= 1'b0;
      splitReq_q  <= 1'b0;
      dataOut_q   <= 8'd0;
      dataValid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      readAddr_q  <= readAddr_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      splitAck_q  <= splitAck_d;
      splitReq_q  <= splitReq_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      dropped_q   <= dropped_d;
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[strobeAddr] <= target_data_in;
    end
  end

  assign target_data_out       = dataOut_q;
  assign target_data_out_valid = dataValid_q;
  assign target_ready          = ready_q;
  assign target_ack            = ack_q;
  assign target_split_ack      = splitAck_q;
  assign split_req             = splitReq_q;
  assign txn_dropped           = dropped_q;

endmodule

// File: tb/tb_split_target_mem.sv
// Scoreboard bench for split_target_mem: stimulus tasks queue the expected
// pulse events (kind, cycle, data); a negedge monitor pops and compares them.
module tb_split_target_mem;

  typedef enum {EV_ACK, EV_SPLIT, EV_DATA, EV_DROP} evKind_t;
  typedef struct {
    evKind_t    kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid;
  logic [7:0]  target_data_in;
  logic        target_data_in_valid;
  logic        split_grant;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;
  logic        target_ready;
  logic        target_ack;
  logic        target_split_ack;
  logic        split_req;
  logic        txn_dropped;

  ev_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  split_target_mem dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .target_addr_in        (target_addr_in),
    .target_addr_in_valid  (target_addr_in_valid),
    .target_data_in        (target_data_in),
    .target_data_in_valid  (target_data_in_valid),
    .split_grant           (split_grant),
    .target_data_out       (target_data_out),
    .target_data_out_valid (target_data_out_valid),
    .target_ready          (target_ready),
    .target_ack            (target_ack),
    .target_split_ack      (target_split_ack),
    .split_req             (split_req),
    .txn_dropped           (txn_dropped)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: an output registered at edge N is seen with cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Direct value comparison.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, actual, expected);
    end
  endtask

  // Pop the next expected event and compare kind, cycle and data.
  task automatic checkEvent(input evKind_t k, input logic [7:0] d);
    ev_t e;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected %s at cycle %0d (data 0x%02h), nothing expected",
               k.name(), cyc, d);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == EV_DATA && e.data !== d)) begin
        mismatched++;
        $display("[TB] FAIL event: got %s cyc %0d data 0x%02h, want %s cyc %0d data 0x%02h",
                 k.name(), cyc, d, e.kind.name(), e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every pulse output the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (target_ack)            checkEvent(EV_ACK, 8'd0);
      if (target_split_ack)      checkEvent(EV_SPLIT, 8'd0);
      if (target_data_out_valid) checkEvent(EV_DATA, target_data_out);
      if (txn_dropped)           checkEvent(EV_DROP, 8'd0);
    end
  end

  // Advance (from just after an edge) until cyc reaches target.
  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle strobe; e returns the edge that samples it.
  task automatic applyStimulus(input logic av, input logic dv, input logic [15:0] addr,
                               input logic [7:0] data, output int e);
    e                    = cyc + 1;
    target_addr_in       = addr;
    target_data_in       = data;
    target_addr_in_valid = av;
    target_data_in_valid = dv;
    @(posedge clk);
    #1;
    target_addr_in_valid = 1'b0;
    target_data_in_valid = 1'b0;
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [7:0] data);
    int e;
    applyStimulus(1'b1, 1'b1, addr, data, e);
    expQ.push_back('{EV_ACK, e, 8'd0});
  endtask

  task automatic startRead(input logic [15:0] addr, output int e);
    applyStimulus(1'b1, 1'b0, addr, 8'd0, e);
    expQ.push_back('{EV_SPLIT, e, 8'd0});
    checkOutput("readyAfterRead", int'(target_ready), 0);
  endtask

  // Grant w cycles after split_req rises, expect the byte and the closing ack.
  task automatic finishRead(input int e, input int w, input logic [7:0] expData);
    int g;
    waitUntil(e + 7);
    checkOutput("splitReqEarly", int'(split_req), 0);
    waitUntil(e + 8);
    checkOutput("splitReqRise", int'(split_req), 1);
    waitUntil(e + 8 + w);
    if (w > 0) checkOutput("splitReqHeld", int'(split_req), 1);
    split_grant = 1'b1;
    g = e + 9 + w;
    expQ.push_back('{EV_DATA, g, expData});
    expQ.push_back('{EV_ACK, g + 9, 8'd0});
    @(posedge clk);
    #1;
    split_grant = 1'b0;
    waitUntil(g + 8);
    checkOutput("splitReqTx", int'(split_req), 1);
    checkOutput("readyTx", int'(target_ready), 0);
    waitUntil(g + 9);
    checkOutput("splitReqDone", int'(split_req), 0);
    checkOutput("readyDone", int'(target_ready), 1);
    checkOutput("dataOutClear", int'(target_data_out), 0);
  endtask

  // Directed test sequence.
  initial begin
    int e;
    int d;
    logic [7:0] bbData [4];
    bbData[0] = 8'h11; bbData[1] = 8'h22; bbData[2] = 8'h33; bbData[3] = 8'h44;

    rst_n                = 1'b1;
    target_addr_in       = 16'd0;
    target_addr_in_valid = 1'b0;
    target_data_in       = 8'd0;
    target_data_in_valid = 1'b0;
    split_grant          = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resetReady", int'(target_ready), 1);
    checkOutput("resetSplitReq", int'(split_req), 0);
    checkOutput("resetAck", int'(target_ack), 0);
    checkOutput("resetDataValid", int'(target_data_out_valid), 0);
    checkOutput("resetDataOut", int'(target_data_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] write then read");
    doWrite(16'h0123, 8'hA5);
    checkOutput("readyAfterWrite", int'(target_ready), 1);
    startRead(16'h0123, e);
    finishRead(e, 0, 8'hA5);

    $display("[TB] grant delay");
    startRead(16'h0123, e);
    finishRead(e, 20, 8'hA5);

    $display("[TB] busy drop");
    startRead(16'h0123, e);
    waitUntil(e + 2);
    applyStimulus(1'b1, 1'b1, 16'h0123, 8'h3C, d);
    expQ.push_back('{EV_DROP, d, 8'd0});
    finishRead(e, 0, 8'hA5);

    $display("[TB] back-to-back writes");
    for (int i = 0; i < 4; i++) doWrite(16'(i), bbData[i]);
    for (int i = 0; i < 4; i++) begin
      startRead(16'(i), e);
      finishRead(e, i, bbData[i]);
    end

    $display("[TB] aliasing and data-only strobe");
    doWrite(16'hF005, 8'h7E);
    applyStimulus(1'b0, 1'b1, 16'h0005, 8'h99, d);
    repeat (2) @(posedge clk);
    #1;
    startRead(16'h0005, e);
    finishRead(e, 1, 8'h7E);

    $display("[TB] reset during REQ");
    startRead(16'h0002, e);
    waitUntil(e + 11);
    checkOutput("splitReqBeforeReset", int'(split_req), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("resetSplitReqDrop", int'(split_req), 0);
    checkOutput("resetNoDataValid", int'(target_data_out_valid), 0);
    checkOutput("resetNoAck", int'(target_ack), 0);
    checkOutput("resetReadyHigh", int'(target_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterRelease", int'(target_ready), 1);
    startRead(16'h0123, e);
    finishRead(e, 2, 8'hA5);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pendingEvents", expQ.size(), 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
